lc3_ctrl_fsm: RTL and testbench

- Next-generation LC-3 instruction sequencer/decoder. Drives every datapath load, gate and mux select, plus the SRAM strobes.
- Adds a parametrised memory wait-state count, a PAUSE enable, LD/ST/LEA support, TRAP-as-halt, and a Busy status output.
- Sits between the IR/NZP/BEN logic and the datapath/SRAM interface, and replaces the fixed-timing control unit.

---
 rtl/lc3_ctrl_fsm_pkg.sv | 57 +++++
 rtl/lc3_ctrl_fsm_if.sv | 33 +++
 rtl/lc3_ctrl_fsm_mem_timer.sv | 29 ++
 rtl/lc3_ctrl_fsm.sv | 180 ++++++++++++++++++
 tb/tb_lc3_ctrl_fsm.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/lc3_ctrl_fsm_pkg.sv
// Shared types and encodings for the LC-3 control sequencer.
package lc3_ctrl_pkg;

    typedef enum logic [4:0] {
        S_HALTED,
        S_FETCH_MAR,
        S_FETCH_RD,
        S_FETCH_IR,
        S_DECODE,
        S_ADD,
        S_AND,
        S_NOT,
        S_BR_TAKEN,
        S_JMP,
        S_JSR_LINK,
        S_JSR_JUMP,
        S_LDR_ADDR,
        S_LD_ADDR,
        S_STR_ADDR,
        S_ST_ADDR,
        S_RD_DATA,
        S_LD_WB,
        S_ST_MDR,
        S_WR_DATA,
        S_LEA,
        S_PAUSE1,
        S_PAUSE2
    } state_t;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_PSE  = 4'b1101;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    localparam logic [1:0] PCMUX_INC   = 2'b00;
    localparam logic [1:0] PCMUX_ADDER = 2'b10;

    localparam logic [1:0] ADDR2_ZERO  = 2'b00;
    localparam logic [1:0] ADDR2_OFF6  = 2'b01;
    localparam logic [1:0] ADDR2_OFF9  = 2'b10;
    localparam logic [1:0] ADDR2_OFF11 = 2'b11;

    localparam logic [1:0] ALUK_ADD   = 2'b00;
    localparam logic [1:0] ALUK_AND   = 2'b01;
    localparam logic [1:0] ALUK_NOT   = 2'b10;
    localparam logic [1:0] ALUK_PASSA = 2'b11;

endpackage

// File: rtl/lc3_ctrl_fsm_if.sv
// Control bundle between the sequencer (slave side) and the IR/datapath/SRAM (master side).
interface lc3_ctrl_if;
    logic       Run;
    logic       Continue;
    logic [3:0] Opcode;
    logic       IR_5;
    logic       BEN;

    logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic       GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0] PCMUX;
    logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX;
    logic [1:0] ADDR2MUX;
    logic [1:0] ALUK;
    logic       Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;
    logic       Busy;

    modport master (
        output Run, Continue, Opcode, IR_5, BEN,
        input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
        input  GatePC, GateMDR, GateALU, GateMARMUX,
        input  PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK,
        input  Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, Busy
    );

    modport slave (
        input  Run, Continue, Opcode, IR_5, BEN,
        output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
        output GatePC, GateMDR, GateALU, GateMARMUX,
        output PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK,
        output Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, Busy
    );
endinterface

// File: rtl/lc3_ctrl_fsm_mem_timer.sv
// SRAM wait-state timer shared by the read and write states.
// Loads MEM_CYCLES-1 when a memory state is about to be entered, then counts
// down to zero and parks there, so it can never wrap.
module lc3_mem_timer #(
    parameter int MEM_CYCLES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_start,
    output logic o_active,
    output logic o_last
);
    localparam logic [3:0] LOAD_VAL = 4'(MEM_CYCLES - 1);

    logic [3:0] r_cnt;

    // Load on start, otherwise count down and hold at zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= 4'd0;
        else if (i_start)
            r_cnt <= LOAD_VAL;
        else if (r_cnt != 4'd0)
            r_cnt <= r_cnt - 4'd1;
    end

    assign o_active = (r_cnt != 4'd0);
    assign o_last   = (r_cnt == 4'd0);
endmodule

// File: rtl/lc3_ctrl_fsm.sv
// LC-3 instruction sequencer: Moore FSM driving datapath loads, gates, mux
// selects and the active-low SRAM strobes, with a parametrised wait-state count.
module lc3_ctrl_fsm
    import lc3_ctrl_pkg::*;
#(
    parameter int MEM_CYCLES = 2,
    parameter bit PAUSE_EN   = 1'b1
) (
    input  logic      Clk,
    input  logic      Reset_n,
    lc3_ctrl_if.slave bus
);
    state_t r_state;
    logic   w_start;
    logic   w_active;
    logic   w_last;

    // Every state that is always followed by a memory access arms the timer.
    assign w_start = (r_state == S_FETCH_MAR) || (r_state == S_LDR_ADDR) ||
                     (r_state == S_LD_ADDR)   || (r_state == S_ST_MDR);

    lc3_mem_timer #(.MEM_CYCLES(MEM_CYCLES)) u_timer (
        .i_clk    (Clk),
        .i_rst_n  (Reset_n),
        .i_start  (w_start),
        .o_active (w_active),
        .o_last   (w_last)
    );

    // State register and next-state dispatch.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_HALTED;
        end else begin
            case (r_state)
                S_HALTED:    if (bus.Run) r_state <= S_FETCH_MAR;
                S_FETCH_MAR: r_state <= S_FETCH_RD;
                S_FETCH_RD:  if (!w_active) r_state <= S_FETCH_IR;
                S_FETCH_IR:  r_state <= S_DECODE;
                S_DECODE: begin
                    case (bus.Opcode)
                        OP_ADD:  r_state <= S_ADD;
                        OP_AND:  r_state <= S_AND;
                        OP_NOT:  r_state <= S_NOT;
                        OP_BR:   r_state <= bus.BEN ? S_BR_TAKEN : S_FETCH_MAR;
                        OP_JMP:  r_state <= S_JMP;
                        OP_JSR:  r_state <= S_JSR_LINK;
                        OP_LDR:  r_state <= S_LDR_ADDR;
                        OP_LD:   r_state <= S_LD_ADDR;
                        OP_STR:  r_state <= S_STR_ADDR;
                        OP_ST:   r_state <= S_ST_ADDR;
                        OP_LEA:  r_state <= S_LEA;
                        OP_PSE:  r_state <= PAUSE_EN ? S_PAUSE1 : S_FETCH_MAR;
                        OP_TRAP: r_state <= S_HALTED;
                        default: r_state <= S_FETCH_MAR;
                    endcase
                end
                S_JSR_LINK:  r_state <= S_JSR_JUMP;
                S_LDR_ADDR,
                S_LD_ADDR:   r_state <= S_RD_DATA;
                S_RD_DATA:   if (!w_active) r_state <= S_LD_WB;
                S_STR_ADDR,
                S_ST_ADDR:   r_state <= S_ST_MDR;
                S_ST_MDR:    r_state <= S_WR_DATA;
                S_WR_DATA:   if (!w_active) r_state <= S_FETCH_MAR;
                S_PAUSE1:    if (bus.Continue) r_state <= S_PAUSE2;
                S_PAUSE2:    if (!bus.Continue) r_state <= S_FETCH_MAR;
                default:     r_state <= S_FETCH_MAR;
            endcase
        end
    end

    assign bus.Mem_CE = 1'b0;
    assign bus.Mem_UB = 1'b0;
    assign bus.Mem_LB = 1'b0;

    // Moore output decode; Halted (the reset state) yields the idle defaults.
    always_comb begin
        bus.LD_MAR     = 1'b0;
        bus.LD_MDR     = 1'b0;
        bus.LD_IR      = 1'b0;
        bus.LD_BEN     = 1'b0;
        bus.LD_CC      = 1'b0;
        bus.LD_REG     = 1'b0;
        bus.LD_PC      = 1'b0;
        bus.LD_LED     = 1'b0;
        bus.GatePC     = 1'b0;
        bus.GateMDR    = 1'b0;
        bus.GateALU    = 1'b0;
        bus.GateMARMUX = 1'b0;
        bus.PCMUX      = PCMUX_INC;
        bus.DRMUX      = 1'b0;
        bus.SR1MUX     = 1'b0;
        bus.SR2MUX     = 1'b0;
        bus.ADDR1MUX   = 1'b0;
        bus.ADDR2MUX   = ADDR2_ZERO;
        bus.ALUK       = ALUK_ADD;
        bus.Mem_OE     = 1'b1;
        bus.Mem_WE     = 1'b1;
        bus.Busy       = (r_state != S_HALTED);
        case (r_state)
            S_FETCH_MAR: begin
                bus.GatePC = 1'b1;
                bus.LD_MAR = 1'b1;
                bus.LD_PC  = 1'b1;
            end
            S_FETCH_RD, S_RD_DATA: begin
                bus.Mem_OE = 1'b0;
                bus.LD_MDR = w_last;
            end
            S_FETCH_IR: begin
                bus.GateMDR = 1'b1;
                bus.LD_IR   = 1'b1;
            end
            S_DECODE: bus.LD_BEN = 1'b1;
            S_ADD, S_AND, S_NOT: begin
                bus.GateALU = 1'b1;
                bus.LD_REG  = 1'b1;
                bus.LD_CC   = 1'b1;
                bus.SR2MUX  = (r_state != S_NOT) && bus.IR_5;
                bus.ALUK    = (r_state == S_ADD) ? ALUK_ADD :
                              (r_state == S_AND) ? ALUK_AND : ALUK_NOT;
            end
            S_BR_TAKEN: begin
                bus.ADDR2MUX = ADDR2_OFF9;
                bus.PCMUX    = PCMUX_ADDER;
                bus.LD_PC    = 1'b1;
            end
            S_JMP: begin
                bus.ADDR1MUX = 1'b1;
                bus.PCMUX    = PCMUX_ADDER;
                bus.LD_PC    = 1'b1;
            end
            S_JSR_LINK: begin
                bus.GatePC = 1'b1;
                bus.DRMUX  = 1'b1;
                bus.LD_REG = 1'b1;
            end
            S_JSR_JUMP: begin
                bus.ADDR2MUX = ADDR2_OFF11;
                bus.PCMUX    = PCMUX_ADDER;
                bus.LD_PC    = 1'b1;
            end
            S_LDR_ADDR, S_STR_ADDR: begin
                bus.ADDR1MUX   = 1'b1;
                bus.ADDR2MUX   = ADDR2_OFF6;
                bus.GateMARMUX = 1'b1;
                bus.LD_MAR     = 1'b1;
            end
            S_LD_ADDR, S_ST_ADDR: begin
                bus.ADDR2MUX   = ADDR2_OFF9;
                bus.GateMARMUX = 1'b1;
                bus.LD_MAR     = 1'b1;
            end
            S_LD_WB: begin
                bus.GateMDR = 1'b1;
                bus.LD_REG  = 1'b1;
                bus.LD_CC   = 1'b1;
            end
            S_ST_MDR: begin
                bus.SR1MUX  = 1'b1;
                bus.ALUK    = ALUK_PASSA;
                bus.GateALU = 1'b1;
                bus.LD_MDR  = 1'b1;
            end
            S_WR_DATA: begin
                bus.Mem_WE  = 1'b0;
                bus.GateMDR = 1'b1;
            end
            S_LEA: begin
                bus.ADDR2MUX   = ADDR2_OFF9;
                bus.GateMARMUX = 1'b1;
                bus.LD_REG     = 1'b1;
                bus.LD_CC      = 1'b1;
            end
            S_PAUSE1, S_PAUSE2: bus.LD_LED = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_lc3_ctrl_fsm.sv
// Scoreboard bench for lc3_ctrl_fsm: two instances (3 wait states with pause,
// 1 wait state without pause) share one stimulus bus; one is active at a time.
module tb_lc3_ctrl_fsm;

    typedef struct packed {
        logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic [1:0] pcmux;
        logic       drmux, sr1mux, sr2mux, addr1mux;
        logic [1:0] addr2mux;
        logic [1:0] aluk;
        logic       mem_ce, mem_ub, mem_lb, mem_oe, mem_we, busy;
    } outs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a_n, rst_b_n, sel;
    logic       run, cont, ir5, ben;
    logic [3:0] opc;

    lc3_ctrl_if bus_a();
    lc3_ctrl_if bus_b();

    assign bus_a.Run = run;  assign bus_a.Continue = cont; assign bus_a.Opcode = opc;
    assign bus_a.IR_5 = ir5; assign bus_a.BEN = ben;
    assign bus_b.Run = run;  assign bus_b.Continue = cont; assign bus_b.Opcode = opc;
    assign bus_b.IR_5 = ir5; assign bus_b.BEN = ben;

    lc3_ctrl_fsm #(.MEM_CYCLES(3), .PAUSE_EN(1'b1)) dut_a (.Clk(clk), .Reset_n(rst_a_n), .bus(bus_a));
    lc3_ctrl_fsm #(.MEM_CYCLES(1), .PAUSE_EN(1'b0)) dut_b (.Clk(clk), .Reset_n(rst_b_n), .bus(bus_b));

    outs_t act_a, act_b, act;
    assign act_a = {bus_a.LD_MAR, bus_a.LD_MDR, bus_a.LD_IR, bus_a.LD_BEN, bus_a.LD_CC,
                    bus_a.LD_REG, bus_a.LD_PC, bus_a.LD_LED, bus_a.GatePC, bus_a.GateMDR,
                    bus_a.GateALU, bus_a.GateMARMUX, bus_a.PCMUX, bus_a.DRMUX, bus_a.SR1MUX,
                    bus_a.SR2MUX, bus_a.ADDR1MUX, bus_a.ADDR2MUX, bus_a.ALUK, bus_a.Mem_CE,
                    bus_a.Mem_UB, bus_a.Mem_LB, bus_a.Mem_OE, bus_a.Mem_WE, bus_a.Busy};
    assign act_b = {bus_b.LD_MAR, bus_b.LD_MDR, bus_b.LD_IR, bus_b.LD_BEN, bus_b.LD_CC,
                    bus_b.LD_REG, bus_b.LD_PC, bus_b.LD_LED, bus_b.GatePC, bus_b.GateMDR,
                    bus_b.GateALU, bus_b.GateMARMUX, bus_b.PCMUX, bus_b.DRMUX, bus_b.SR1MUX,
                    bus_b.SR2MUX, bus_b.ADDR1MUX, bus_b.ADDR2MUX, bus_b.ALUK, bus_b.Mem_CE,
                    bus_b.Mem_UB, bus_b.Mem_LB, bus_b.Mem_OE, bus_b.Mem_WE, bus_b.Busy};
    assign act = sel ? act_b : act_a;

    outs_t expq[$];
    outs_t m_exp;
    int    checks = 0;
    int    errors = 0;
    int    mc;
    bit    pe;
    bit    halted;

    // Monitor: one expected output bundle per clock cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            m_exp = expq.pop_front();
            checks++;
            if (act !== m_exp) begin
                errors++;
                $display("FAIL outputs t=%0t dut=%s got %07h want %07h", $time,
                         sel ? "b" : "a", act, m_exp);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    function automatic outs_t idle_o();
        outs_t o;
        o = '0;
        o.mem_oe = 1'b1;
        o.mem_we = 1'b1;
        return o;
    endfunction

    function automatic outs_t busy_o();
        outs_t o;
        o = idle_o();
        o.busy = 1'b1;
        return o;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, got, want);
        end
    endtask

    // Expected bundle for the current cycle, then advance to just after the next edge.
    task automatic cyc(input outs_t e);
        expq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Reference model: the full cycle sequence one instruction produces.
    task automatic run_instr(input logic [3:0] op, input logic i5, input logic b, input bit rst_wr);
        outs_t e;
        int    k1, k2;
        if (halted) begin
            run = 1'b0;
            repeat ($urandom_range(3, 0)) cyc(idle_o());
            run = 1'b1;
            cyc(idle_o());
            run = 1'b0;
            halted = 1'b0;
        end
        // fetch: operands only matter in DECODE, so scramble them before it
        opc = 4'($urandom); ben = 1'($urandom); ir5 = 1'($urandom);
        e = busy_o(); e.gate_pc = 1; e.ld_mar = 1; e.ld_pc = 1; cyc(e);
        for (int i = 0; i < mc; i++) begin
            e = busy_o(); e.mem_oe = 0; e.ld_mdr = (i == mc - 1); cyc(e);
        end
        e = busy_o(); e.gate_mdr = 1; e.ld_ir = 1; cyc(e);
        opc = op; ben = b; ir5 = i5;
        e = busy_o(); e.ld_ben = 1; cyc(e);
        case (op)
            4'b0001, 4'b0101, 4'b1001: begin
                e = busy_o(); e.gate_alu = 1; e.ld_reg = 1; e.ld_cc = 1;
                e.sr2mux = (op == 4'b1001) ? 1'b0 : i5;
                e.aluk = (op == 4'b0001) ? 2'b00 : (op == 4'b0101) ? 2'b01 : 2'b10;
                cyc(e);
            end
            4'b0000: if (b) begin
                e = busy_o(); e.addr2mux = 2'b10; e.pcmux = 2'b10; e.ld_pc = 1; cyc(e);
            end
            4'b1100: begin
                e = busy_o(); e.addr1mux = 1; e.pcmux = 2'b10; e.ld_pc = 1; cyc(e);
            end
            4'b0100: begin
                e = busy_o(); e.gate_pc = 1; e.drmux = 1; e.ld_reg = 1; cyc(e);
                e = busy_o(); e.addr2mux = 2'b11; e.pcmux = 2'b10; e.ld_pc = 1; cyc(e);
            end
            4'b0110, 4'b0010: begin
                e = busy_o(); e.gate_marmux = 1; e.ld_mar = 1;
                e.addr1mux = (op == 4'b0110); e.addr2mux = (op == 4'b0110) ? 2'b01 : 2'b10;
                cyc(e);
                for (int i = 0; i < mc; i++) begin
                    e = busy_o(); e.mem_oe = 0; e.ld_mdr = (i == mc - 1); cyc(e);
                end
                e = busy_o(); e.gate_mdr = 1; e.ld_reg = 1; e.ld_cc = 1; cyc(e);
            end
            4'b0111, 4'b0011: begin
                e = busy_o(); e.gate_marmux = 1; e.ld_mar = 1;
                e.addr1mux = (op == 4'b0111); e.addr2mux = (op == 4'b0111) ? 2'b01 : 2'b10;
                cyc(e);
                e = busy_o(); e.sr1mux = 1; e.aluk = 2'b11; e.gate_alu = 1; e.ld_mdr = 1; cyc(e);
                for (int i = 0; i < mc; i++) begin
                    if (rst_wr && i == 0) begin
                        chk("we_low_before_reset", 32'(act.mem_we), 32'd0);
                        expq.push_back(idle_o());
                        #1 rst_a_n = 1'b0;
                        #1;
                        chk("we_released_by_reset", 32'(act.mem_we), 32'd1);
                        chk("oe_high_in_reset", 32'(act.mem_oe), 32'd1);
                        chk("busy_low_in_reset", 32'(act.busy), 32'd0);
                        @(posedge clk); #1;
                        cyc(idle_o());
                        rst_a_n = 1'b1;
                        run = 1'b0;
                        repeat (10) cyc(idle_o());
                        halted = 1'b1;
                        return;
                    end
                    e = busy_o(); e.mem_we = 0; e.gate_mdr = 1; cyc(e);
                end
            end
            4'b1110: begin
                e = busy_o(); e.addr2mux = 2'b10; e.gate_marmux = 1; e.ld_reg = 1; e.ld_cc = 1;
                cyc(e);
            end
            4'b1101: if (pe) begin
                k1 = $urandom_range(3, 0);
                k2 = $urandom_range(3, 0);
                e = busy_o(); e.ld_led = 1;
                for (int i = 0; i <= k1; i++) begin cont = (i == k1); cyc(e); end
                for (int i = 0; i <= k2; i++) begin cont = (i != k2); cyc(e); end
                cont = 1'b0;
            end
            4'b1111: halted = 1'b1;
            default: ;
        endcase
    endtask

    initial begin
        rst_a_n = 1'b0; rst_b_n = 1'b0; sel = 1'b0;
        run = 1'b0; cont = 1'b0; ir5 = 1'b0; ben = 1'b0; opc = 4'h0;
        halted = 1'b1;

        // instance A: 3 wait states, pause enabled
        mc = 3; pe = 1'b1;
        @(posedge clk); #1;
        cyc(idle_o());
        cyc(idle_o());
        rst_a_n = 1'b1;
        repeat (4) cyc(idle_o());
        run_instr(4'b0001, 1'b1, 1'b0, 1'b0);
        run_instr(4'b0000, 1'b0, 1'b0, 1'b0);
        run_instr(4'b0000, 1'b0, 1'b1, 1'b0);
        run_instr(4'b0011, 1'b0, 1'b0, 1'b0);
        run_instr(4'b1101, 1'b0, 1'b0, 1'b0);
        run_instr(4'b1111, 1'b0, 1'b0, 1'b0);
        run_instr(4'b0110, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 80; n++)
            run_instr(4'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        run_instr(4'b0011, 1'b0, 1'b0, 1'b1);

        // instance B: 1 wait state, pause disabled
        rst_a_n = 1'b0;
        sel = 1'b1; mc = 1; pe = 1'b0; halted = 1'b1;
        cyc(idle_o());
        rst_b_n = 1'b1;
        repeat (3) cyc(idle_o());
        run_instr(4'b0011, 1'b0, 1'b0, 1'b0);
        run_instr(4'b1101, 1'b0, 1'b0, 1'b0);
        run_instr(4'b0010, 1'b0, 1'b0, 1'b0);
        run_instr(4'b0101, 1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 80; n++)
            run_instr(4'($urandom), 1'($urandom), 1'($urandom), 1'b0);

        @(posedge clk); #1;
        chk("scoreboard_drained", 32'(expq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
